// File: rtl/eprobe_led_sequencer_pkg.sv
// eprobe_pkg: shared command modes, sequencer state encoding and default widths.
package eprobe_pkg;
   localparam int DEF_ADDR_W   = 10;
   localparam int DEF_VLED_W   = 3;
   localparam int DEF_SETTLE_W = 8;
   typedef logic [1:0] mode_t;
   localparam mode_t MODE_NOP    = 2'b00;
   localparam mode_t MODE_SINGLE = 2'b01;
   localparam mode_t MODE_RANGE  = 2'b10;
   localparam mode_t MODE_ALL    = 2'b11;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SETUP = 2'd1;
   localparam logic [1:0] LOAD  = 2'd2;
endpackage

// File: rtl/eprobe_led_sequencer_if.sv
// eprobe_led_sequencer_if: host command handshake plus pad-side drive outputs.
interface eprobe_led_sequencer_if import eprobe_pkg::*; #(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int VLED_W   = DEF_VLED_W,
   parameter int SETTLE_W = DEF_SETTLE_W
);
   logic                cmd_valid;
   logic                cmd_ready;
   mode_t               cmd_mode;
   logic [ADDR_W-1:0]   cmd_start;
   logic [ADDR_W-1:0]   cmd_end;
   logic [VLED_W-1:0]   cmd_vled;
   logic                cmd_en;
   logic [SETTLE_W-1:0] cmd_settle;
   logic                abort;
   logic [ADDR_W-1:0]   led_addr;
   logic [VLED_W-1:0]   vled;
   logic                en_led;
   logic                load;
   logic                busy;
   logic                done;
   logic                err;
   modport master (output cmd_valid, cmd_mode, cmd_start, cmd_end, cmd_vled, cmd_en, cmd_settle, abort,
                   input cmd_ready, led_addr, vled, en_led, load, busy, done, err);
   modport slave  (input cmd_valid, cmd_mode, cmd_start, cmd_end, cmd_vled, cmd_en, cmd_settle, abort,
                   output cmd_ready, led_addr, vled, en_led, load, busy, done, err);
endinterface

// File: rtl/eprobe_led_sequencer_settle_timer.sv
// eprobe_settle_timer: loadable down-counter; expire_o marks the last settle cycle.
module eprobe_settle_timer import eprobe_pkg::*; #(
   parameter int SETTLE_W = DEF_SETTLE_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic [SETTLE_W-1:0] value_i,
   output logic                expire_o
);
   logic [SETTLE_W-1:0] cnt_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else if (start_i) cnt_q <= value_i;
      else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
   end
   assign expire_o = cnt_q == '0;
endmodule

// File: rtl/eprobe_led_sequencer.sv
// eprobe_led_sequencer: walks SINGLE/RANGE/ALL pixel commands, settling then strobing load per address.
module eprobe_led_sequencer import eprobe_pkg::*; #(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int VLED_W   = DEF_VLED_W,
   parameter int SETTLE_W = DEF_SETTLE_W
) (
   input logic                    clk,
   input logic                    rst,
   eprobe_led_sequencer_if.slave  bus_io
);
   logic [1:0]          state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d, end_q, end_d, first, last;
   logic [VLED_W-1:0]   vled_q, vled_d;
   logic [SETTLE_W-1:0] settle_q, settle_d, tmr_val;
   logic                en_q, en_d, load_q, load_d, done_q, done_d, err_q, err_d;
   logic                tmr_start, expire, rng_bad;
   assign first   = bus_io.cmd_mode == MODE_ALL ? '0 : bus_io.cmd_start;
   assign last    = bus_io.cmd_mode == MODE_SINGLE ? bus_io.cmd_start :
                    bus_io.cmd_mode == MODE_ALL ? '1 : bus_io.cmd_end;
   assign rng_bad = bus_io.cmd_mode == MODE_RANGE && bus_io.cmd_end < bus_io.cmd_start;
   // the first settle period is loaded straight from the command, later ones from the latched copy
   assign tmr_val = state_q == IDLE ? bus_io.cmd_settle : settle_q;
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      end_d     = end_q;
      vled_d    = vled_q;
      en_d      = en_q;
      settle_d  = settle_q;
      load_d    = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      tmr_start = 1'b0;
      case (state_q)
         IDLE: if (bus_io.cmd_valid && bus_io.cmd_mode != MODE_NOP) begin
            if (rng_bad) err_d = 1'b1;
            else begin
               state_d   = SETUP;
               addr_d    = first;
               end_d     = last;
               vled_d    = bus_io.cmd_vled;
               en_d      = bus_io.cmd_en;
               settle_d  = bus_io.cmd_settle;
               tmr_start = 1'b1;
            end
         end
         SETUP: if (bus_io.abort) state_d = IDLE;
            else if (expire) begin
               state_d = LOAD;
               load_d  = 1'b1;
            end
         LOAD: if (bus_io.abort) state_d = IDLE;
            else if (addr_q == end_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               state_d   = SETUP;
               addr_d    = addr_q + 1'b1;
               tmr_start = 1'b1;
            end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         end_q    <= '0;
         vled_q   <= '0;
         en_q     <= 1'b0;
         settle_q <= '0;
         load_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         end_q    <= end_d;
         vled_q   <= vled_d;
         en_q     <= en_d;
         settle_q <= settle_d;
         load_q   <= load_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end
   eprobe_settle_timer #(.SETTLE_W(SETTLE_W)) u_timer (
      .clk(clk), .rst(rst), .start_i(tmr_start), .value_i(tmr_val), .expire_o(expire)
   );
   assign bus_io.cmd_ready = state_q == IDLE;
   assign bus_io.busy      = state_q != IDLE;
   assign bus_io.led_addr  = addr_q;
   assign bus_io.vled      = vled_q;
   assign bus_io.en_led    = en_q;
   assign bus_io.load      = load_q;
   assign bus_io.done      = done_q;
   assign bus_io.err       = err_q;
endmodule

// File: tb/tb_eprobe_led_sequencer.sv
// tb_eprobe_led_sequencer: directed stimulus with a pulse scoreboard for load/done/err events.
module tb_eprobe_led_sequencer;
   import eprobe_pkg::*;
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0, errors = 0, checks = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   typedef struct {int kind; int cyc; int addr;} ev_t;
   ev_t qa[$], qb[$];
   ev_t oa, ea, ob, eb;
   eprobe_led_sequencer_if #(.ADDR_W(10), .VLED_W(3), .SETTLE_W(8)) ia ();
   eprobe_led_sequencer_if #(.ADDR_W(4),  .VLED_W(3), .SETTLE_W(8)) ib ();
   eprobe_led_sequencer #(.ADDR_W(10), .VLED_W(3), .SETTLE_W(8)) dut_a (.clk(clk), .rst(rst), .bus_io(ia.slave));
   eprobe_led_sequencer #(.ADDR_W(4),  .VLED_W(3), .SETTLE_W(8)) dut_b (.clk(clk), .rst(rst), .bus_io(ib.slave));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input int addr, input int v, input int en, input int rdy);
      chk({tag, "_addr"}, 64'(ia.led_addr), 64'(addr));
      chk({tag, "_vled"}, 64'(ia.vled), 64'(v));
      chk({tag, "_en"}, 64'(ia.en_led), 64'(en));
      chk({tag, "_ready"}, 64'(ia.cmd_ready), 64'(rdy));
      chk({tag, "_busy"}, 64'(ia.busy), 64'(rdy == 0));
   endtask

   // drives one command on DUT A (caller is mid-cycle), then queues the pulses it should produce
   task automatic send(input mode_t m, input int s, input int e, input int v, input int en,
                       input int st, input int npush, input bit pdone);
      int a, n, f;
      ia.cmd_valid = 1'b1; ia.cmd_mode = m; ia.cmd_start = 10'(s); ia.cmd_end = 10'(e);
      ia.cmd_vled = 3'(v); ia.cmd_en = en[0]; ia.cmd_settle = 8'(st);
      @(posedge clk); #1;
      a = cyc;
      ia.cmd_valid = 1'b0; ia.cmd_mode = 2'($urandom); ia.cmd_start = 10'($urandom);
      ia.cmd_end = 10'($urandom); ia.cmd_vled = 3'($urandom); ia.cmd_en = 1'($urandom);
      ia.cmd_settle = 8'($urandom);
      f = (m == MODE_ALL) ? 0 : s;
      n = (m == MODE_SINGLE) ? 1 : (m == MODE_ALL) ? 1024 : e - s + 1;
      if (m == MODE_RANGE && e < s) qa.push_back(ev_t'{2, a, 0});
      else if (m != MODE_NOP) begin
         for (int p = 1; p <= n && p <= npush; p++) qa.push_back(ev_t'{0, a + p * (st + 2) - 1, f + p - 1});
         if (pdone) qa.push_back(ev_t'{1, a + n * (st + 2), 0});
      end
   endtask

   always @(negedge clk) if (ia.load || ia.done || ia.err) begin
      oa = ev_t'{ia.load ? 0 : ia.done ? 1 : 2, cyc, ia.load ? int'(ia.led_addr) : 0};
      ea = ev_t'{-1, -1, -1};
      if (qa.size() > 0) ea = qa.pop_front();
      chk("a_kind", 64'(oa.kind), 64'(ea.kind));
      chk("a_cycle", 64'(oa.cyc), 64'(ea.cyc));
      chk("a_addr", 64'(oa.addr), 64'(ea.addr));
   end

   always @(negedge clk) if (ib.load || ib.done || ib.err) begin
      ob = ev_t'{ib.load ? 0 : ib.done ? 1 : 2, cyc, ib.load ? int'(ib.led_addr) : 0};
      eb = ev_t'{-1, -1, -1};
      if (qb.size() > 0) eb = qb.pop_front();
      chk("b_kind", 64'(ob.kind), 64'(eb.kind));
      chk("b_cycle", 64'(ob.cyc), 64'(eb.cyc));
      chk("b_addr", 64'(ob.addr), 64'(eb.addr));
   end

   initial begin
      int a;
      rst = 1'b1;
      ia.cmd_valid = 0; ia.cmd_mode = 0; ia.cmd_start = 0; ia.cmd_end = 0;
      ia.cmd_vled = 0; ia.cmd_en = 0; ia.cmd_settle = 0; ia.abort = 0;
      ib.cmd_valid = 0; ib.cmd_mode = 0; ib.cmd_start = 0; ib.cmd_end = 0;
      ib.cmd_vled = 0; ib.cmd_en = 0; ib.cmd_settle = 0; ib.abort = 0;
      repeat (2) @(negedge clk);
      chk_a("reset", 0, 0, 0, 1);
      chk("reset_pulses", 64'({ia.load, ia.done, ia.err}), 64'(0));
      @(negedge clk) rst = 1'b0;
      @(negedge clk) send(MODE_RANGE, 10, 20, 6, 1, 1, 2, 1'b0);
      repeat (6) @(negedge clk);
      #1 rst = 1'b1;
      #1 chk_a("rst_mid", 0, 0, 0, 1);
      chk("rst_mid_pulses", 64'({ia.load, ia.done, ia.err}), 64'(0));
      @(negedge clk) rst = 1'b0;
      @(negedge clk) send(MODE_SINGLE, 3, 0, 2, 1, 0, 1, 1'b1);
      repeat (3) @(negedge clk);
      chk_a("single3", 3, 2, 1, 1);
      @(negedge clk) send(MODE_SINGLE, 'h155, 0, 5, 1, 2, 1, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk_a($sformatf("s155_c%0d", k), 'h155, 5, 1, 0);
      end
      repeat (2) @(negedge clk);
      chk_a("s155_done", 'h155, 5, 1, 1);
      send(MODE_RANGE, 5, 7, 1, 0, 0, 3, 1'b1);
      repeat (7) @(negedge clk);
      chk_a("rng_done", 7, 1, 0, 1);
      @(negedge clk) send(MODE_RANGE, 9, 3, 4, 1, 0, 0, 1'b0);
      @(negedge clk) chk_a("err_c1", 7, 1, 0, 1);
      send(MODE_NOP, 100, 200, 6, 1, 0, 0, 1'b0);
      repeat (3) @(negedge clk);
      chk_a("nop", 7, 1, 0, 1);
      ia.abort = 1'b1;
      @(negedge clk) ia.abort = 1'b0;
      chk_a("abort_idle", 7, 1, 0, 1);
      send(MODE_RANGE, 0, 1023, 3, 1, 1, 3, 1'b0);
      repeat (10) @(negedge clk);
      chk_a("abort_c10", 3, 3, 1, 0);
      ia.abort = 1'b1;
      @(negedge clk) ia.abort = 1'b0;
      chk_a("abort_c11", 3, 3, 1, 1);
      repeat (4) @(negedge clk);
      chk_a("abort_hold", 3, 3, 1, 1);
      @(negedge clk);
      ib.cmd_valid = 1'b1; ib.cmd_mode = MODE_ALL; ib.cmd_start = 4'd5; ib.cmd_end = 4'd2;
      ib.cmd_vled = 3'd7; ib.cmd_en = 1'b1; ib.cmd_settle = 8'd0;
      @(posedge clk); #1;
      a = cyc;
      ib.cmd_valid = 1'b0; ib.cmd_settle = 8'd9;
      for (int p = 1; p <= 16; p++) qb.push_back(ev_t'{0, a + 2 * p - 1, p - 1});
      qb.push_back(ev_t'{1, a + 32, 0});
      repeat (33) @(negedge clk);
      chk("all_addr", 64'(ib.led_addr), 64'(15));
      chk("all_ready", 64'(ib.cmd_ready), 64'(1));
      repeat (3) @(negedge clk);
      chk("all_nowrap", 64'(ib.led_addr), 64'(15));
      chk("qa_empty", 64'(qa.size()), 64'(0));
      chk("qb_empty", 64'(qb.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
